dm_cache_ctrl: RTL and testbench

//  Parametrised direct-mapped read cache with write-through, sitting between the CPU bus and backing memory.

---
 rtl/dm_cache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through read cache with burst refill and hit/miss counters
module dm_cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 5,
  parameter int OFFS_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFS_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = LINES * (2 ** OFFS_W);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [OFFS_W-1:0]   r_beat;
  logic [LINES-1:0]    r_valid;
  logic [DATA_W-1:0]   r_data [WORDS];
  logic [TAG_W-1:0]    r_tag  [LINES];

  logic [TAG_W-1:0]          w_tag;
  logic [INDEX_W-1:0]        w_idx;
  logic [OFFS_W-1:0]         w_offs;
  logic                      w_hit;
  logic [DATA_W-1:0]         w_line_word;
  logic [DATA_W-1:0]         w_resp_word;
  logic                      w_beat_ack;
  logic                      w_last_ack;
  logic                      w_data_we;
  logic [INDEX_W+OFFS_W-1:0] w_data_waddr;
  logic [DATA_W-1:0]         w_data_wval;

  assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx       = r_addr[OFFS_W +: INDEX_W];
  assign w_offs      = r_addr[OFFS_W-1:0];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line_word = r_data[{w_idx, w_offs}];
  assign w_beat_ack  = (r_state == S_REFILL) && mem_req && mem_ack;
  assign w_last_ack  = w_beat_ack && (&r_beat);
  // On the final beat the requested word is either arriving now or already in the line
  assign w_resp_word = (w_offs == r_beat) ? mem_rdata : w_line_word;
  assign busy        = (r_state != S_IDLE);

  // Single data-array write port shared by refill beats and write-hit updates
  always_comb begin
    w_data_we    = 1'b0;
    w_data_waddr = {w_idx, w_offs};
    w_data_wval  = r_wdata;
    if (w_beat_ack) begin
      w_data_we    = 1'b1;
      w_data_waddr = {w_idx, r_beat};
      w_data_wval  = mem_rdata;
    end else if ((r_state == S_LOOKUP) && r_we && w_hit) begin
      w_data_we    = 1'b1;
    end
  end

  // Data and tag arrays: no reset, validity is tracked by r_valid alone
  always_ff @(posedge clk) begin
    if (w_data_we) begin
      r_data[w_data_waddr] <= w_data_wval;
    end
    if (w_last_ack) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  // Controller FSM with registered CPU/memory outputs and statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_beat    <= '0;
      r_valid   <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inv_all) begin
            r_valid <= '0;
          end else if (cpu_req && !cpu_ready) begin
            // The ready cycle itself still sees the old request held, so it is skipped
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (r_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= r_wdata;
            r_state   <= S_WRITE;
          end else if (w_hit) begin
            cpu_rdata <= w_line_word;
            cpu_ready <= 1'b1;
            if (hit_cnt != '1) begin
              hit_cnt <= hit_cnt + CNT_W'(1);
            end
            r_state   <= S_IDLE;
          end else begin
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
            r_beat   <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {w_tag, w_idx, {OFFS_W{1'b0}}};
            r_state  <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (w_beat_ack) begin
            mem_req <= 1'b0;
            r_beat  <= r_beat + OFFS_W'(1);
            if (w_last_ack) begin
              r_valid[w_idx] <= 1'b1;
              cpu_rdata      <= w_resp_word;
              cpu_ready      <= 1'b1;
              r_state        <= S_RESP;
            end
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {w_tag, w_idx, r_beat};
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        inv_all = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        busy;

  logic        s_req = 1'b0;
  logic [15:0] s_addr = 16'h0;
  logic [7:0]  s_rdata;
  logic        s_ready;
  logic        s_mreq;
  logic        s_mwe;
  logic [15:0] s_maddr;
  logic [7:0]  s_mwdata;
  logic [7:0]  s_mrdata = 8'h0;
  logic        s_mack = 1'b0;
  logic [1:0]  s_hit;
  logic [1:0]  s_miss;
  logic        s_busy;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .inv_all(inv_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .busy(busy)
  );

  dm_cache_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(s_addr),
    .cpu_wdata(8'h00), .cpu_rdata(s_rdata), .cpu_ready(s_ready), .inv_all(1'b0),
    .mem_req(s_mreq), .mem_we(s_mwe), .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_rdata(s_mrdata), .mem_ack(s_mack), .hit_cnt(s_hit), .miss_cnt(s_miss), .busy(s_busy)
  );

  typedef struct {
    logic [7:0]  data;
    bit          chk;
    int          lat;
    logic [15:0] hit;
    logic [15:0] miss;
    int          t0;
  } resp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  resp_t rq[$];
  resp_t sq[$];
  beat_t mq[$];
  logic [7:0] mem [65536];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int req_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Response monitor for the main instance
  always @(negedge clk) begin
    resp_t r;
    if (!rst && cpu_ready) begin
      if (rq.size() == 0) begin
        chk("unexpected_cpu_ready", 32'(cpu_rdata), 32'hFFFF_FFFF);
      end else begin
        r = rq.pop_front();
        if (r.chk) chk("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
        if (r.lat >= 0) chk("hit_latency", 32'(cyc - r.t0), 32'(r.lat));
        chk("hit_cnt", 32'(hit_cnt), 32'(r.hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(r.miss));
      end
    end
  end

  // Response monitor for the saturation instance
  always @(negedge clk) begin
    resp_t r;
    if (!rst && s_ready) begin
      if (sq.size() == 0) begin
        chk("sat_unexpected_ready", 32'(s_rdata), 32'hFFFF_FFFF);
      end else begin
        r = sq.pop_front();
        chk("sat_rdata", 32'(s_rdata), 32'(r.data));
        chk("sat_hit_cnt", 32'(s_hit), 32'(r.hit));
        chk("sat_miss_cnt", 32'(s_miss), 32'(r.miss));
      end
    end
  end

  // Backing memory with programmable ack delay; checks each completed beat
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mem_ack  = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem[mem_addr];
        if (mq.size() == 0) begin
          chk("unexpected_mem_beat", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          b = mq.pop_front();
          chk("mem_we", 32'(mem_we), 32'(b.we));
          chk("mem_addr", 32'(mem_addr), 32'(b.addr));
          if (b.we) chk("mem_wdata", 32'(mem_wdata), 32'(b.data));
        end
      end
    end else if (wait_cnt != 0) begin
      req_drops++;
      wait_cnt = 0;
    end
  end

  // Trivial responder for the saturation instance: word = low address byte
  always @(negedge clk) begin
    if (rst || s_mack) begin
      s_mack = 1'b0;
    end else if (s_mreq) begin
      s_mack   = 1'b1;
      s_mrdata = s_maddr[7:0];
    end
  end

  task automatic push_beat(input logic we, input logic [15:0] a, input logic [7:0] d);
    beat_t b;
    b.we = we; b.addr = a; b.data = d;
    mq.push_back(b);
  endtask

  task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] ed, input bit dchk, input int lat,
                         input logic [15:0] eh, input logic [15:0] em);
    resp_t r;
    int n;
    @(negedge clk);
    r.data = ed; r.chk = dchk; r.lat = lat; r.hit = eh; r.miss = em; r.t0 = cyc;
    rq.push_back(r);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 300);
    cpu_req = 1'b0;
    chk("cpu_ready_seen", 32'(cpu_ready), 32'h1);
  endtask

  task automatic sat_txn(input logic [15:0] a, input logic [7:0] ed, input logic [1:0] eh,
                         input logic [1:0] em);
    resp_t r;
    int n;
    @(negedge clk);
    r.data = ed; r.chk = 1'b1; r.lat = -1; r.hit = 16'(eh); r.miss = 16'(em); r.t0 = cyc;
    sq.push_back(r);
    s_req = 1'b1; s_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 100);
    s_req = 1'b0;
    chk("sat_ready_seen", 32'(s_ready), 32'h1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
    mem[16'h1234] = 8'hA0; mem[16'h1235] = 8'hA1; mem[16'h1236] = 8'hA2; mem[16'h1237] = 8'hA3;
    mem[16'h9234] = 8'hB0; mem[16'h9235] = 8'hB1; mem[16'h9236] = 8'hB2; mem[16'h9237] = 8'hB3;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("reset_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_hit_cnt", 32'(hit_cnt), 32'h0);
    chk("reset_miss_cnt", 32'(miss_cnt), 32'h0);

    // Cold miss, ascending burst from offset 0, then hit on the same line
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h1234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h1234, 8'h00, 8'hA0, 1'b1, -1, 16'd0, 16'd1);
    cpu_txn(1'b0, 16'h1236, 8'h00, 8'hA2, 1'b1, 2, 16'd1, 16'd1);

    // Write-through hit, then the updated word is served from the cache
    push_beat(1'b1, 16'h1235, 8'h5A);
    cpu_txn(1'b1, 16'h1235, 8'h5A, 8'h00, 1'b0, -1, 16'd1, 16'd1);
    cpu_txn(1'b0, 16'h1235, 8'h00, 8'h5A, 1'b1, 2, 16'd2, 16'd1);

    // Same index with a new tag evicts; the original tag misses again
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h9234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h9234, 8'h00, 8'hB0, 1'b1, -1, 16'd2, 16'd2);
    push_beat(1'b0, 16'h1234, 8'h00); push_beat(1'b0, 16'h1235, 8'h00);
    push_beat(1'b0, 16'h1236, 8'h00); push_beat(1'b0, 16'h1237, 8'h00);
    cpu_txn(1'b0, 16'h1235, 8'h00, 8'h5A, 1'b1, -1, 16'd2, 16'd3);

    // Write miss goes to memory only; the resident line is untouched
    push_beat(1'b1, 16'hF001, 8'h77);
    cpu_txn(1'b1, 16'hF001, 8'h77, 8'h00, 1'b0, -1, 16'd2, 16'd3);
    cpu_txn(1'b0, 16'h1237, 8'h00, 8'hA3, 1'b1, 2, 16'd3, 16'd3);

    // Global invalidate turns a resident line into a miss
    @(negedge clk);
    chk("idle_before_inv", 32'(busy), 32'h0);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h1234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h1234, 8'h00, 8'hA0, 1'b1, -1, 16'd3, 16'd4);
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h9234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h9234, 8'h00, 8'hB0, 1'b1, -1, 16'd3, 16'd5);

    // Reset while beat 2 of a refill is outstanding
    ack_delay = 3;
    push_beat(1'b0, 16'h1234, 8'h00); push_beat(1'b0, 16'h1235, 8'h00);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    n = 0;
    while (!(mem_req && mem_addr == 16'h1236) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("beat2_reached", 32'(mem_addr), 32'h1236);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst_mem_req_drop", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h1234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h1234, 8'h00, 8'hA0, 1'b1, -1, 16'd0, 16'd1);

    // Slow memory: request must stay up for every beat
    ack_delay = 5;
    req_drops = 0;
    for (int i = 0; i < 4; i++) push_beat(1'b0, 16'h9234 + 16'(i), 8'h00);
    cpu_txn(1'b0, 16'h9236, 8'h00, 8'hB2, 1'b1, -1, 16'd0, 16'd2);
    chk("mem_req_held", 32'(req_drops), 32'h0);
    ack_delay = 0;
    cpu_txn(1'b0, 16'h9237, 8'h00, 8'hB3, 1'b1, 2, 16'd1, 16'd2);

    // Counter saturation on a 2-bit counter instance
    sat_txn(16'h0010, 8'h10, 2'd0, 2'd1);
    sat_txn(16'h0011, 8'h11, 2'd1, 2'd1);
    sat_txn(16'h0012, 8'h12, 2'd2, 2'd1);
    sat_txn(16'h0013, 8'h13, 2'd3, 2'd1);
    sat_txn(16'h0011, 8'h11, 2'd3, 2'd1);
    sat_txn(16'h0010, 8'h10, 2'd3, 2'd1);

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'h0);
    chk("mem_queue_drained", 32'(mq.size()), 32'h0);
    chk("sat_queue_drained", 32'(sq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
